input_conditioner: RTL

//   Parametrised multi-channel input front end for asynchronous board inputs
//   (buttons, switches). It sits directly behind the pad input buffers and ahead of the CPU MMIO/IO logic.
//   Per channel: optional polarity inversion, N-stage synchroniser, saturating-counter debouncer,
//   and one-cycle rising/falling edge pulses.

---
 rtl/input_conditioner.sv | 73 +++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input front end: optional inversion, synchroniser, saturating-count
// debouncer and one-cycle rise/fall pulses for asynchronous pad inputs.
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] inRaw_i,
  output logic [WIDTH-1:0] synced_o,
  output logic [WIDTH-1:0] debounced_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int SCW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW  = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0]  CNT_MAX     = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]                  condIn;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SCW-1:0]                    sampleCnt_q, sampleCnt_d;
  logic                              samplePulse;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  prev_q;

  assign condIn      = ACTIVE_LOW ? ~inRaw_i : inRaw_i;
  assign synced_o    = sync_q[SYNC_STAGES-1];
  assign samplePulse = (sampleCnt_q == SAMPLE_LAST);
  assign sampleCnt_d = samplePulse ? '0 : sampleCnt_q + SCW'(1);

  // A low synced level clears immediately; highs only advance on a sample pulse.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!synced_o[i]) begin
        cnt_d[i] = '0;
      end else if (samplePulse && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    debounced_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      debounced_o[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  assign rise_o = debounced_o & ~prev_q;
  assign fall_o = ~debounced_o & prev_q;

  // Clearing prev_q with the counters suppresses a fall pulse on reset mid-press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      sampleCnt_q <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], condIn};
      sampleCnt_q <= sampleCnt_d;
      cnt_q       <= cnt_d;
      prev_q      <= debounced_o;
    end
  end

endmodule
